// File: rtl/layer_sched_responder_if.sv
// ----------------------------------------------------------------------------
// layer_sched_responder_if
//
// Bundles the command bus from the CNN top-level sequencer together with the
// tile handshake (compute array) and the weight-slice handshake (data-transfer
// block) seen by the layer scheduler.
//
// Modports:
//   master : environment side (sequencer, compute array, data-transfer block).
//            Drives the command fields, RAM-ready levels and done pulses.
//            Observes the requests and the status levels.
//   slave  : layer_sched_responder side, the exact opposite directions.
//
// Signals:
//   layer_type              [3:0]   0 init, 1 conv, 2 pool, 3 fc, 9 finish
//   layer_num               [LAYER_NUM_WIDTH-1:0]  command tag
//   fm_size_out             [FM_SIZE_WIDTH-1:0]    output map side
//   kernel_num              [KERNEL_NUM_WIDTH-1:0] kernels / channels
//   init_fm_ram_ready       feature-map RAM init complete (level)
//   init_weight_ram_ready   weight RAM init complete (level)
//   tile_done               tile acknowledge (pulse)
//   weight_update_done      slice update acknowledge (pulse)
//   tile_start              one-cycle tile request
//   tile_row, tile_col      tile origin
//   kernel_group            current kernel group
//   update_weight_ram       one-cycle slice update request
//   update_weight_ram_addr  slice index
//   layer_ready             layer complete (level)
//   finished                finish command received (level)
// ----------------------------------------------------------------------------
interface layer_sched_if #(
    parameter int LAYER_NUM_WIDTH         = 4,
    parameter int FM_SIZE_WIDTH           = 8,
    parameter int KERNEL_NUM_WIDTH        = 8,
    parameter int WEIGHT_WRITE_ADDR_WIDTH = 8
);
    logic [3:0]                         layer_type;
    logic [LAYER_NUM_WIDTH-1:0]         layer_num;
    logic [FM_SIZE_WIDTH-1:0]           fm_size_out;
    logic [KERNEL_NUM_WIDTH-1:0]        kernel_num;
    logic                               init_fm_ram_ready;
    logic                               init_weight_ram_ready;
    logic                               tile_done;
    logic                               weight_update_done;

    logic                               tile_start;
    logic [FM_SIZE_WIDTH-1:0]           tile_row;
    logic [FM_SIZE_WIDTH-1:0]           tile_col;
    logic [KERNEL_NUM_WIDTH-1:0]        kernel_group;
    logic                               update_weight_ram;
    logic [WEIGHT_WRITE_ADDR_WIDTH-1:0] update_weight_ram_addr;
    logic                               layer_ready;
    logic                               finished;

    modport master (
        output layer_type, layer_num, fm_size_out, kernel_num,
               init_fm_ram_ready, init_weight_ram_ready,
               tile_done, weight_update_done,
        input  tile_start, tile_row, tile_col, kernel_group,
               update_weight_ram, update_weight_ram_addr,
               layer_ready, finished
    );

    modport slave (
        input  layer_type, layer_num, fm_size_out, kernel_num,
               init_fm_ram_ready, init_weight_ram_ready,
               tile_done, weight_update_done,
        output tile_start, tile_row, tile_col, kernel_group,
               update_weight_ram, update_weight_ram_addr,
               layer_ready, finished
    );
endinterface

// File: rtl/layer_sched_responder.sv
// ----------------------------------------------------------------------------
// layer_sched_responder
//
// Layer-side responder to the CNN top-level sequencer. Every change of
// layer_num is a new command: the layer configuration is latched and the
// output tile schedule is walked (columns inner, rows middle, kernel groups
// outer). One tile request or one weight-slice update is outstanding at a
// time. Between kernel groups of conv/fc layers the next weight slice is
// requested. When the whole layer is acknowledged, layer_ready is raised and
// held until the next command. A finish command (type 9) latches finished
// until reset.
//
// Ports:
//   clk          single clock, all state on the rising edge
//   rst          asynchronous, active-low reset
//   bus          layer_sched_if.slave (command, tile and weight handshakes)
//   busy_cycles  [23:0] cycles spent working on the current layer
//                (present only when LAYER_SCHED_PERF_EN is defined)
//
// Build option:
//   LAYER_SCHED_PERF_EN  adds the saturating busy_cycles counter.
// ----------------------------------------------------------------------------
module layer_sched_responder #(
    parameter int LAYER_NUM_WIDTH         = 4,
    parameter int FM_SIZE_WIDTH           = 8,
    parameter int KERNEL_NUM_WIDTH        = 8,
    parameter int WEIGHT_WRITE_ADDR_WIDTH = 8,
    parameter int PARA_X                  = 3,
    parameter int PARA_Y                  = 3,
    parameter int PARA_KERNEL             = 2
) (
    input  logic        clk,
    input  logic        rst,
    layer_sched_if.slave bus
`ifdef LAYER_SCHED_PERF_EN
    ,
    output logic [23:0] busy_cycles
`endif
);

    localparam logic [3:0] TYPE_INIT   = 4'd0;
    localparam logic [3:0] TYPE_CONV   = 4'd1;
    localparam logic [3:0] TYPE_POOL   = 4'd2;
    localparam logic [3:0] TYPE_FC     = 4'd3;
    localparam logic [3:0] TYPE_FINISH = 4'd9;

    // One extra bit on the coordinate and two on the kernel base so that
    // "current + step" never overflows before it is compared to the limit.
    localparam int FW = FM_SIZE_WIDTH + 1;
    localparam int KW = KERNEL_NUM_WIDTH + 2;

    localparam logic [FW-1:0] STEP_X    = FW'(PARA_X);
    localparam logic [FW-1:0] STEP_Y    = FW'(PARA_Y);
    localparam logic [KW-1:0] STEP_K    = KW'(PARA_KERNEL);
    localparam logic [KW-1:0] STEP_K_FC = KW'(PARA_Y * PARA_KERNEL);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ISSUE,
        S_WAIT,
        S_WUPD,
        S_WWAIT,
        S_DONE,
        S_FIN
    } state_t;

    state_t                             state;
    logic [LAYER_NUM_WIDTH-1:0]         num_q;
    logic [3:0]                         type_q;
    logic [FM_SIZE_WIDTH-1:0]           fm_q;
    logic [KERNEL_NUM_WIDTH-1:0]        kn_q;
    logic [FM_SIZE_WIDTH-1:0]           row_q;
    logic [FM_SIZE_WIDTH-1:0]           col_q;
    logic [KERNEL_NUM_WIDTH-1:0]        grp_q;
    logic [KW-1:0]                      kbase_q;
    logic [WEIGHT_WRITE_ADDR_WIDTH-1:0] addr_q;
    logic                               tile_start_q;
    logic                               upd_q;
    logic                               ready_q;
    logic                               fin_q;

    logic          new_cmd;
    logic          cmd_known;
    logic          cmd_uses_fm;
    logic          cmd_uses_kn;
    logic          cmd_degen;
    logic          is_fc;
    logic [FW-1:0] row_next;
    logic [FW-1:0] col_next;
    logic [KW-1:0] k_step;
    logic [KW-1:0] kbase_next;
    logic          row_last;
    logic          col_last;
    logic          grp_last;

    // Once finished, the block no longer listens to commands until reset.
    assign new_cmd = (state != S_FIN) && (bus.layer_num != num_q);

    // Types outside the known set (including 10..15) complete immediately,
    // as do conv/pool with an empty map and conv/pool/fc with no kernels.
    assign cmd_known   = (bus.layer_type == TYPE_INIT) || (bus.layer_type == TYPE_CONV) ||
                         (bus.layer_type == TYPE_POOL) || (bus.layer_type == TYPE_FC)   ||
                         (bus.layer_type == TYPE_FINISH);
    assign cmd_uses_fm = (bus.layer_type == TYPE_CONV) || (bus.layer_type == TYPE_POOL);
    assign cmd_uses_kn = cmd_uses_fm || (bus.layer_type == TYPE_FC);
    assign cmd_degen   = !cmd_known ||
                         (cmd_uses_fm && (bus.fm_size_out == '0)) ||
                         (cmd_uses_kn && (bus.kernel_num == '0));

    // The schedule limits are found by stepping a counter and comparing the
    // next origin with the latched size, which gives ceil(size/step) tiles
    // without any divider. An fc layer is a single tile per group and each
    // group covers PARA_Y * PARA_KERNEL kernels.
    assign is_fc      = (type_q == TYPE_FC);
    assign row_next   = {1'b0, row_q} + STEP_X;
    assign col_next   = {1'b0, col_q} + STEP_Y;
    assign k_step     = is_fc ? STEP_K_FC : STEP_K;
    assign kbase_next = kbase_q + k_step;
    assign row_last   = is_fc || (row_next >= {1'b0, fm_q});
    assign col_last   = is_fc || (col_next >= {1'b0, fm_q});
    assign grp_last   = (kbase_next >= {2'b00, kn_q});

    // Main scheduler. Request pulses are registered so that they appear
    // exactly one cycle after the event that triggers them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            num_q        <= '0;
            type_q       <= '0;
            fm_q         <= '0;
            kn_q         <= '0;
            row_q        <= '0;
            col_q        <= '0;
            grp_q        <= '0;
            kbase_q      <= '0;
            addr_q       <= '0;
            tile_start_q <= 1'b0;
            upd_q        <= 1'b0;
            ready_q      <= 1'b0;
            fin_q        <= 1'b0;
        end else begin
            tile_start_q <= 1'b0;
            upd_q        <= 1'b0;
            if (new_cmd) begin
                // A new command aborts whatever is in flight; a late
                // acknowledge for the aborted work lands in ISSUE and is lost.
                num_q   <= bus.layer_num;
                type_q  <= bus.layer_type;
                fm_q    <= bus.fm_size_out;
                kn_q    <= bus.kernel_num;
                row_q   <= '0;
                col_q   <= '0;
                grp_q   <= '0;
                kbase_q <= '0;
                addr_q  <= '0;
                ready_q <= 1'b0;
                if (bus.layer_type == TYPE_FINISH) begin
                    fin_q <= 1'b1;
                    state <= S_FIN;
                end else if (cmd_degen) begin
                    ready_q <= 1'b1;
                    state   <= S_DONE;
                end else if (bus.layer_type == TYPE_INIT) begin
                    state <= S_INIT;
                end else begin
                    tile_start_q <= 1'b1;
                    state        <= S_ISSUE;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                    end
                    S_INIT: begin
                        if (bus.init_fm_ram_ready && bus.init_weight_ram_ready) begin
                            ready_q <= 1'b1;
                            state   <= S_DONE;
                        end
                    end
                    S_ISSUE: begin
                        state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (bus.tile_done) begin
                            if (!col_last) begin
                                col_q        <= col_next[FM_SIZE_WIDTH-1:0];
                                tile_start_q <= 1'b1;
                                state        <= S_ISSUE;
                            end else if (!row_last) begin
                                col_q        <= '0;
                                row_q        <= row_next[FM_SIZE_WIDTH-1:0];
                                tile_start_q <= 1'b1;
                                state        <= S_ISSUE;
                            end else if (!grp_last) begin
                                col_q   <= '0;
                                row_q   <= '0;
                                grp_q   <= grp_q + KERNEL_NUM_WIDTH'(1);
                                kbase_q <= kbase_next;
                                // Pooling has no weights, so it moves straight
                                // to the next channel group.
                                if (type_q == TYPE_POOL) begin
                                    tile_start_q <= 1'b1;
                                    state        <= S_ISSUE;
                                end else begin
                                    upd_q <= 1'b1;
                                    state <= S_WUPD;
                                end
                            end else begin
                                ready_q <= 1'b1;
                                state   <= S_DONE;
                            end
                        end
                    end
                    S_WUPD: begin
                        state <= S_WWAIT;
                    end
                    S_WWAIT: begin
                        if (bus.weight_update_done) begin
                            addr_q       <= addr_q + WEIGHT_WRITE_ADDR_WIDTH'(1);
                            tile_start_q <= 1'b1;
                            state        <= S_ISSUE;
                        end
                    end
                    S_DONE: begin
                    end
                    S_FIN: begin
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.tile_start             = tile_start_q;
    assign bus.tile_row               = row_q;
    assign bus.tile_col               = col_q;
    assign bus.kernel_group           = grp_q;
    assign bus.update_weight_ram      = upd_q;
    assign bus.update_weight_ram_addr = addr_q;
    assign bus.layer_ready            = ready_q;
    assign bus.finished               = fin_q;

`ifdef LAYER_SCHED_PERF_EN
    // Counts every cycle spent working on a layer (init wait included) and
    // freezes once the layer is done; a new command restarts it from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_cycles <= '0;
        end else if (new_cmd) begin
            busy_cycles <= '0;
        end else if ((state != S_IDLE) && (state != S_DONE) && (state != S_FIN) &&
                     (busy_cycles != 24'hFFFFFF)) begin
            busy_cycles <= busy_cycles + 24'd1;
        end
    end
`endif

endmodule
